// File: rtl/img_pkg.sv
// ---------------------------------------------------------------------------
// img_pkg
//   Shared constants and types for the edge-detect image pipeline.
//   - Default frame geometry (WIDTH x HEIGHT) and pixel widths.
//   - Bit positions of the R/G/B channels inside a packed 24-bit pixel.
//   - Reciprocal-multiply constants for an exact floor(x/3) over 0..765.
//   - Front-stage FSM state encoding.
//   - rgb_sum(): zero-extended R+G+B of a packed pixel.
// ---------------------------------------------------------------------------
package img_pkg;

  localparam int WIDTH      = 720;
  localparam int HEIGHT     = 540;
  localparam int DWIDTH_IN  = 24;
  localparam int DWIDTH_OUT = 8;

  localparam int CH_W  = 8;
  localparam int R_LSB = 16;
  localparam int G_LSB = 8;
  localparam int B_LSB = 0;

  // Largest sum is 3*255 = 765, which needs 10 bits.
  localparam int SUM_W = 10;

  // (s*683)>>11 equals floor(s/3) for every s in 0..765.
  // The largest product is 765*683 = 522495, so a 20-bit product is plenty.
  localparam int DIV3_MUL   = 683;
  localparam int DIV3_SHIFT = 11;
  localparam int PROD_W     = 20;

  typedef enum logic [0:0] {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  function automatic logic [SUM_W-1:0] rgb_sum(input logic [DWIDTH_IN-1:0] pix);
    logic [SUM_W-1:0] r;
    logic [SUM_W-1:0] g;
    logic [SUM_W-1:0] b;
    r = SUM_W'(pix[R_LSB +: CH_W]);
    g = SUM_W'(pix[G_LSB +: CH_W]);
    b = SUM_W'(pix[B_LSB +: CH_W]);
    return r + g + b;
  endfunction

endpackage

// File: rtl/rgb_gray_datapath.sv
// ---------------------------------------------------------------------------
// rgb_gray_datapath
//   Two-stage RGB -> gray pipeline with valid bits.
//     S1: sum_q  = R+G+B            (valid v1_q)
//     S2: gray_q = (sum_q*683)>>11  (valid v2_q)
//   All stage registers move together when adv_i is high and hold otherwise,
//   so a stalled output never loses or duplicates a pixel.
//
// Ports
//   clock        in   clock
//   reset        in   async reset, active-high
//   adv_i        in   pipeline advance enable
//   pix_valid_i  in   a pixel is being accepted into S1 this cycle
//   pix_i        in   packed {R,G,B} pixel
//   v2_o         out  S2 holds a valid gray pixel
//   gray_o       out  S2 gray value
// ---------------------------------------------------------------------------
module rgb_gray_datapath
  import img_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  adv_i,
  input  logic                  pix_valid_i,
  input  logic [DWIDTH_IN-1:0]  pix_i,
  output logic                  v2_o,
  output logic [DWIDTH_OUT-1:0] gray_o
);

  logic [SUM_W-1:0]      sum_q;
  logic [SUM_W-1:0]      sum_d;
  logic                  v1_q;
  logic [DWIDTH_OUT-1:0] gray_q;
  logic [DWIDTH_OUT-1:0] gray_d;
  logic                  v2_q;

  assign sum_d = rgb_sum(pix_i);

  // The cast keeps only the 8 result bits above the shift; the product
  // never reaches bit 19, so nothing meaningful is dropped.
  assign gray_d = DWIDTH_OUT'((PROD_W'(sum_q) * PROD_W'(DIV3_MUL)) >> DIV3_SHIFT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q  <= '0;
      v1_q   <= 1'b0;
      gray_q <= '0;
      v2_q   <= 1'b0;
    end else if (adv_i) begin
      sum_q  <= sum_d;
      v1_q   <= pix_valid_i;
      gray_q <= gray_d;
      v2_q   <= v1_q;
    end
  end

  assign v2_o   = v2_q;
  assign gray_o = gray_q;

endmodule

// File: rtl/rgb_to_gray_stage.sv
// ---------------------------------------------------------------------------
// rgb_to_gray_stage
//   Front stage of the edge-detect pipeline. Pops RGB pixels from a FWFT
//   input FIFO, converts each to gray = floor((R+G+B)/3) through a 2-stage
//   pipeline and pushes the result into the output FIFO. One pixel per
//   cycle, 2-cycle latency, full backpressure.
//
//   After the last pixel of a frame has been popped, the stage stops popping
//   until that frame has fully drained into the output FIFO, then pulses
//   frame_done for one cycle and resumes with the next frame.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   S_RUN   | popping pixels of the current frame
//   S_FLUSH | all pixels of the frame popped; waiting for the last write
//
// Ports
//   clock           in   clock
//   reset           in   async reset, active-high
//   fifo_in_rd_en   out  pop input FIFO
//   fifo_in_dout    in   RGB pixel at head of input FIFO
//   fifo_in_empty   in   input FIFO empty
//   fifo_out_wr_en  out  push output FIFO
//   fifo_out_din    out  gray pixel
//   fifo_out_full   in   output FIFO full
//   frame_done      out  1-cycle pulse after the last pixel of a frame is written
// ---------------------------------------------------------------------------
module rgb_to_gray_stage
  import img_pkg::*;
#(
  parameter int WIDTH  = img_pkg::WIDTH,
  parameter int HEIGHT = img_pkg::HEIGHT
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  fifo_in_rd_en,
  input  logic [DWIDTH_IN-1:0]  fifo_in_dout,
  input  logic                  fifo_in_empty,
  output logic                  fifo_out_wr_en,
  output logic [DWIDTH_OUT-1:0] fifo_out_din,
  input  logic                  fifo_out_full,
  output logic                  frame_done
);

  localparam int NPIX  = WIDTH * HEIGHT;
  localparam int CNT_W = (NPIX > 1) ? $clog2(NPIX) : 1;
  localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(NPIX - 1);

  state_e           state_q;
  state_e           state_d;
  logic [CNT_W-1:0] rd_cnt_q;
  logic [CNT_W-1:0] rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q;
  logic [CNT_W-1:0] wr_cnt_d;
  logic             frame_done_q;
  logic             frame_done_d;

  logic             adv;
  logic             v2;
  logic             rd_en;
  logic             wr_en;

  // S2 can move whenever it is empty or its pixel is being written out.
  assign adv   = !v2 || !fifo_out_full;
  assign wr_en = v2 && !fifo_out_full;
  // Reset is folded in so no pop is reported while the stage is held in
  // reset, even though the state register already reads S_RUN.
  assign rd_en = !reset && (state_q == S_RUN) && !fifo_in_empty && adv;

  rgb_gray_datapath u_datapath (
    .clock       (clock),
    .reset       (reset),
    .adv_i       (adv),
    .pix_valid_i (rd_en),
    .pix_i       (fifo_in_dout),
    .v2_o        (v2),
    .gray_o      (fifo_out_din)
  );

  always_comb begin
    state_d      = state_q;
    rd_cnt_d     = rd_cnt_q;
    wr_cnt_d     = wr_cnt_q;
    frame_done_d = 1'b0;

    if (rd_en) begin
      rd_cnt_d = rd_cnt_q + 1'b1;
    end
    if (wr_en) begin
      wr_cnt_d = wr_cnt_q + 1'b1;
    end

    case (state_q)
      S_RUN: begin
        if (rd_en && (rd_cnt_q == LAST_PIX)) begin
          rd_cnt_d = '0;
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // The last write of a frame always lands here: the pipeline is two
        // deep, so it trails the last pop by at least two cycles.
        if (wr_en && (wr_cnt_q == LAST_PIX)) begin
          wr_cnt_d     = '0;
          frame_done_d = 1'b1;
          state_d      = S_RUN;
        end
      end
      default: begin
        state_d  = S_RUN;
        rd_cnt_d = '0;
        wr_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= S_RUN;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_cnt_q     <= rd_cnt_d;
      wr_cnt_q     <= wr_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign fifo_in_rd_en  = rd_en;
  assign fifo_out_wr_en = wr_en;
  assign frame_done     = frame_done_q;

endmodule

// File: tb/tb_rgb_to_gray_stage.sv
// ---------------------------------------------------------------------------
// tb_rgb_to_gray_stage
//   Directed bench for rgb_to_gray_stage with a 4x2 frame. A queue models
//   the FWFT input FIFO; every popped pixel's expected gray value is queued
//   and compared in order against each output write.
// ---------------------------------------------------------------------------
module tb_rgb_to_gray_stage;

  localparam int TW   = 4;
  localparam int TH   = 2;
  localparam int NPIX = TW * TH;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_in_rd_en;
  logic [23:0] fifo_in_dout = '0;
  logic        fifo_in_empty = 1'b1;
  logic        fifo_out_wr_en;
  logic [7:0]  fifo_out_din;
  logic        fifo_out_full = 1'b0;
  logic        frame_done;

  rgb_to_gray_stage #(.WIDTH(TW), .HEIGHT(TH)) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_rd_en  (fifo_in_rd_en),
    .fifo_in_dout   (fifo_in_dout),
    .fifo_in_empty  (fifo_in_empty),
    .fifo_out_wr_en (fifo_out_wr_en),
    .fifo_out_din   (fifo_out_din),
    .fifo_out_full  (fifo_out_full),
    .frame_done     (frame_done)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int gray_model(input logic [23:0] p);
    return (int'(p[23:16]) + int'(p[15:8]) + int'(p[7:0])) / 3;
  endfunction

  logic [23:0] in_q[$];
  int          exp_q[$];
  int          pop_cycs[$];
  int          wr_cycs[$];
  int          fd_cycs[$];

  int cyc = 0;
  bit pop_flag = 0;
  bit rand_mode = 0;
  bit rec = 0;
  int full_lo = -1;
  int full_hi = -2;
  int last_wr_cyc = 0;
  int last_pop_cyc = 0;
  int last_din = 0;
  int wr_total = 0;
  int pops = 0;
  int fd_count = 0;
  int wr_in_frame = 0;
  int pop_in_frame = 0;
  bit wait_fd = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Input/output FIFO models: consume the pop seen in the previous cycle,
  // then present the new head and the (possibly randomised) flags.
  always @(posedge clock) begin
    #1;
    if (pop_flag) begin
      if (in_q.size() > 0) void'(in_q.pop_front());
      pop_flag = 0;
    end
    fifo_in_empty = (in_q.size() == 0) || (rand_mode && ($urandom_range(0, 2) == 0));
    fifo_in_dout  = (in_q.size() > 0) ? in_q[0] : 24'h0;
    fifo_out_full = (rand_mode && ($urandom_range(0, 2) == 0)) ||
                    ((cyc >= full_lo) && (cyc <= full_hi));
  end

  always @(negedge clock) begin
    if (!reset) begin
      if (frame_done) begin
        chk("fd_wr_count", wr_in_frame, NPIX);
        chk("fd_after_wr", cyc - last_wr_cyc, 1);
        wr_in_frame = 0;
        wait_fd = 0;
        fd_count++;
        if (rec) fd_cycs.push_back(cyc);
      end
      if (fifo_out_wr_en) begin
        chk("wr_while_full", int'(fifo_out_full), 0);
        chk("wr_expected", int'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) chk("gray", int'(fifo_out_din), exp_q.pop_front());
        last_wr_cyc = cyc;
        last_din = int'(fifo_out_din);
        wr_in_frame++;
        wr_total++;
        if (rec) wr_cycs.push_back(cyc);
      end
      if (fifo_in_rd_en) begin
        chk("rd_while_empty", int'(fifo_in_empty), 0);
        chk("pop_before_fd", int'(wait_fd), 0);
        exp_q.push_back(gray_model(fifo_in_dout));
        pop_flag = 1;
        last_pop_cyc = cyc;
        pops++;
        pop_in_frame++;
        if (pop_in_frame == NPIX) begin
          wait_fd = 1;
          pop_in_frame = 0;
        end
        if (rec) pop_cycs.push_back(cyc);
      end
    end
  end

  task automatic wait_idle(input int maxc);
    int n = 0;
    while ((in_q.size() != 0 || exp_q.size() != 0) && n < maxc) begin
      @(posedge clock); #3;
      n++;
    end
    chk("idle_timeout", int'(in_q.size() == 0 && exp_q.size() == 0), 1);
    repeat (4) begin
      @(posedge clock); #3;
    end
  endtask

  task automatic send_one(input logic [23:0] pix, input int expv);
    wait_idle(50);
    in_q.push_back(pix);
    wait_idle(50);
    chk("dir_gray", last_din, expv);
    chk("dir_latency", last_wr_cyc - last_pop_cyc, 2);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    int f0;
    int p0;
    int n;
    int r;
    int g;
    int rem;

    // Reset: a queued pixel must not be popped while reset is held.
    in_q.push_back(24'h102030);
    repeat (3) @(negedge clock);
    chk("rst_rd_en", int'(fifo_in_rd_en), 0);
    chk("rst_wr_en", int'(fifo_out_wr_en), 0);
    chk("rst_din", int'(fifo_out_din), 0);
    chk("rst_fd", int'(frame_done), 0);
    in_q.delete();
    @(negedge clock);
    reset = 1'b0;

    // Two full frames back to back.
    @(posedge clock); #3;
    rec = 1;
    for (int i = 0; i < 16; i++) in_q.push_back(24'(i * 24'h030201));
    wait_idle(200);
    rec = 0;
    chk("frm_fd_count", fd_cycs.size(), 2);
    chk("frm_pop_count", pop_cycs.size(), 16);
    chk("frm_wr_count", wr_cycs.size(), 16);
    chk("frm_last_gray", last_din, 30);
    if (fd_cycs.size() == 2 && pop_cycs.size() == 16 && wr_cycs.size() == 16) begin
      chk("frm_rd_drop", int'(pop_cycs[8] - pop_cycs[7] > 1), 1);
      chk("frm_fd1_cyc", fd_cycs[0], wr_cycs[7] + 1);
      chk("frm_pop9_after_fd", int'(pop_cycs[8] >= fd_cycs[0]), 1);
      chk("frm_fd2_cyc", fd_cycs[1], wr_cycs[15] + 1);
    end

    // Single pixels with hand-computed results and latency.
    send_one(24'hFFFFFF, 255);
    send_one(24'h000000, 0);
    send_one(24'h010100, 0);
    send_one(24'h020201, 1);

    // Backpressure window in the middle of a continuous stream.
    wait_idle(50);
    w0 = wr_total;
    full_lo = cyc + 10;
    full_hi = cyc + 14;
    for (int i = 0; i < 20; i++) in_q.push_back({8'(i * 7), 8'(i * 5), 8'(i * 3)});
    wait_idle(200);
    full_lo = -1;
    full_hi = -2;
    chk("bp_count", wr_total - w0, 20);
    chk("bp_last", last_din, 95);

    // Every possible sum, with random empty/full toggling.
    w0 = wr_total;
    rand_mode = 1;
    for (int s = 0; s <= 765; s++) begin
      r = (s > 255) ? 255 : s;
      rem = s - r;
      g = (rem > 255) ? 255 : rem;
      in_q.push_back({8'(r), 8'(g), 8'(rem - g)});
    end
    wait_idle(8000);
    rand_mode = 0;
    chk("sweep_count", wr_total - w0, 766);
    chk("sweep_last", last_din, 255);

    // Reset in the middle of a frame, then a clean full frame.
    p0 = pops;
    for (int i = 0; i < 10; i++) in_q.push_back(24'h405060);
    n = 0;
    while (pops - p0 < 5 && n < 100) begin
      @(negedge clock); #2;
      n++;
    end
    chk("mid_pop_timeout", int'(pops - p0 >= 5), 1);
    reset = 1'b1;
    #1;
    chk("mid_rd_en", int'(fifo_in_rd_en), 0);
    chk("mid_wr_en", int'(fifo_out_wr_en), 0);
    chk("mid_din", int'(fifo_out_din), 0);
    chk("mid_fd", int'(frame_done), 0);
    in_q.delete();
    exp_q.delete();
    pop_flag = 0;
    wr_in_frame = 0;
    pop_in_frame = 0;
    wait_fd = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #3;
    w0 = wr_total;
    f0 = fd_count;
    for (int i = 0; i < NPIX; i++) in_q.push_back(24'(i * 24'h010101));
    wait_idle(200);
    chk("post_rst_wr", wr_total - w0, NPIX);
    chk("post_rst_fd", fd_count - f0, 1);
    chk("post_rst_last", last_din, 7);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
